// File: rtl/game_ctrl_collision_if.sv
// ---------------------------------------------------------------------------
// game_ctrl_collision_if
//
// Purpose : groups the game-controller signals exchanged between the game
//           controller and its surroundings (button, dino/obstacle geometry,
//           game status outputs) into one bundle.
//
// Signals :
//   start_btn        start/restart button, level, debounced
//   dino_h/dino_v    dino upper-left corner (x, y)
//   obstacle_h/v     obstacle upper-right corner (x, y)
//   obstacle_width   obstacle width in pixels
//   obstacle_height  obstacle height in pixels
//   game_state       00 IDLE, 01 RUN, 10 OVER
//   game_over        high while in OVER
//   play_rst         one-cycle restart pulse for obstacle/dino blocks
//   collision        registered raw overlap flag
//   score            current score, binary
//   hi_score         best score since reset (only with HIGH_SCORE_EN)
//
// Modports:
//   master : surrounding logic / testbench (drives geometry and button)
//   slave  : game_ctrl_collision
//
// Build option: HIGH_SCORE_EN adds the hi_score signal.
// ---------------------------------------------------------------------------
interface game_ctrl_collision_if;

    logic        start_btn;
    logic [9:0]  dino_h;
    logic [9:0]  dino_v;
    logic [9:0]  obstacle_h;
    logic [9:0]  obstacle_v;
    logic [7:0]  obstacle_width;
    logic [7:0]  obstacle_height;
    logic [1:0]  game_state;
    logic        game_over;
    logic        play_rst;
    logic        collision;
    logic [13:0] score;
`ifdef HIGH_SCORE_EN
    logic [13:0] hi_score;
`endif

`ifdef HIGH_SCORE_EN
    modport master (
        output start_btn, dino_h, dino_v, obstacle_h, obstacle_v,
               obstacle_width, obstacle_height,
        input  game_state, game_over, play_rst, collision, score, hi_score
    );

    modport slave (
        input  start_btn, dino_h, dino_v, obstacle_h, obstacle_v,
               obstacle_width, obstacle_height,
        output game_state, game_over, play_rst, collision, score, hi_score
    );
`else
    modport master (
        output start_btn, dino_h, dino_v, obstacle_h, obstacle_v,
               obstacle_width, obstacle_height,
        input  game_state, game_over, play_rst, collision, score
    );

    modport slave (
        input  start_btn, dino_h, dino_v, obstacle_h, obstacle_v,
               obstacle_width, obstacle_height,
        output game_state, game_over, play_rst, collision, score
    );
`endif

endinterface : game_ctrl_collision_if

// File: rtl/game_ctrl_collision.sv
// ---------------------------------------------------------------------------
// game_ctrl_collision
//
// Purpose : top-level game controller. Every frame (one clk cycle) it checks
//           the dino bounding box against the obstacle bounding box, runs the
//           IDLE/RUN/OVER game state machine, keeps a saturating score and
//           issues a one-cycle restart pulse to the obstacle and dino blocks.
//
// Ports   :
//   clk   in   game/frame clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of game_ctrl_collision_if
//           in : start_btn, dino_h, dino_v, obstacle_h, obstacle_v,
//                obstacle_width, obstacle_height
//           out: game_state, game_over, play_rst, collision, score
//                (+ hi_score with HIGH_SCORE_EN)
//
// Build option: define HIGH_SCORE_EN to keep the best score of all games
//               since reset on hi_score.
// ---------------------------------------------------------------------------
module game_ctrl_collision #(
    parameter int unsigned DINO_WIDTH   = 40,
    parameter int unsigned DINO_HEIGHT  = 43,
    parameter int unsigned SCORE_DIV    = 6,
    parameter int unsigned SCORE_MAX    = 9999,
    parameter int unsigned GRACE_FRAMES = 30
) (
    input  logic                 clk,
    input  logic                 rst,
    game_ctrl_collision_if.slave bus
);

    localparam int unsigned DIV_W   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int unsigned GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [GRACE_W-1:0] GRACE_END = GRACE_W'(GRACE_FRAMES);
    localparam logic [13:0]        SCORE_SAT = 14'(SCORE_MAX);
    localparam logic [10:0]        DINO_W11  = 11'(DINO_WIDTH);
    localparam logic [10:0]        DINO_H11  = 11'(DINO_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic                 r_start_q;
    logic                 r_collision;
    logic                 r_play_rst;
    logic                 r_game_over;
    logic [13:0]          r_score;
    logic [DIV_W-1:0]     r_div;
    logic [GRACE_W-1:0]   r_grace;
`ifdef HIGH_SCORE_EN
    logic [13:0]          r_hi_score;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_start_rise;
    logic                 w_start_game;
    logic                 w_hit;
    logic                 w_run_tick;
    logic                 w_grace_done;

    logic [10:0]          w_dino_left;
    logic [10:0]          w_dino_right;
    logic [10:0]          w_dino_top;
    logic [10:0]          w_dino_bot;
    logic [10:0]          w_obs_left;
    logic [10:0]          w_obs_right;
    logic [10:0]          w_obs_top;
    logic [10:0]          w_obs_bot;
    logic                 w_obs_empty;
    logic                 w_x_ovl;
    logic                 w_y_ovl;
    logic                 w_overlap;

    assign w_start_rise = bus.start_btn & ~r_start_q;
    assign w_grace_done = (r_grace >= GRACE_END);

    // Bounding-box overlap test. All spans are half-open [lo, hi) in 11 bits
    // so that x+width never wraps; the obstacle is anchored at its right edge.
    always_comb begin
        w_dino_left  = {1'b0, bus.dino_h};
        w_dino_right = {1'b0, bus.dino_h} + DINO_W11;
        w_dino_top   = {1'b0, bus.dino_v};
        w_dino_bot   = {1'b0, bus.dino_v} + DINO_H11;
        w_obs_right  = {1'b0, bus.obstacle_h};
        w_obs_top    = {1'b0, bus.obstacle_v};
        w_obs_bot    = {1'b0, bus.obstacle_v} + {3'b000, bus.obstacle_height};
        w_obs_left   = 11'd0;
        w_obs_empty  = 1'b0;
        w_x_ovl      = 1'b0;
        w_y_ovl      = 1'b0;
        w_overlap    = 1'b0;

        // Obstacle partly scrolled off the left edge clamps to column 0.
        if ({1'b0, bus.obstacle_h} >= {3'b000, bus.obstacle_width}) begin
            w_obs_left = {1'b0, bus.obstacle_h} - {3'b000, bus.obstacle_width};
        end else begin
            w_obs_left = 11'd0;
        end

        if ((bus.obstacle_h == 10'd0) || (bus.obstacle_width == 8'd0)) begin
            w_obs_empty = 1'b1;
        end else begin
            w_obs_empty = 1'b0;
        end

        // Strict comparisons: boxes that only share an edge do not collide.
        w_x_ovl   = (w_dino_left < w_obs_right) && (w_obs_left < w_dino_right);
        w_y_ovl   = (w_dino_top < w_obs_bot) && (w_obs_top < w_dino_bot);
        w_overlap = w_x_ovl && w_y_ovl && !w_obs_empty;
    end

    // Next-state and per-frame control decode for the game FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_game = 1'b0;
        w_hit        = 1'b0;
        w_run_tick   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nxt  = ST_RUN;
                    w_start_game = 1'b1;
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A live hit ends the game and pre-empts this frame's score tick.
                if (r_collision && w_grace_done) begin
                    w_state_nxt = ST_OVER;
                    w_hit       = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_run_tick  = 1'b1;
                end
            end
            ST_OVER: begin
                if (w_start_rise) begin
                    w_state_nxt  = ST_RUN;
                    w_start_game = 1'b1;
                end else begin
                    w_state_nxt  = ST_OVER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Game state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Button edge register and raw collision flag, updated every frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_start_q   <= bus.start_btn;
            r_collision <= w_overlap;
        end
    end

    // Registered status outputs: restart pulse and game-over flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_play_rst  <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_play_rst  <= w_start_game;
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    // Grace counter, score divider and saturating score.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grace <= '0;
            r_div   <= '0;
            r_score <= 14'd0;
        end else if (w_start_game) begin
            r_grace <= '0;
            r_div   <= '0;
            r_score <= 14'd0;
        end else if (w_run_tick) begin
            if (r_grace < GRACE_END) begin
                r_grace <= r_grace + GRACE_W'(1);
            end else begin
                r_grace <= r_grace;
            end

            if (r_div == DIV_LAST) begin
                r_div <= '0;
                if (r_score < SCORE_SAT) begin
                    r_score <= r_score + 14'd1;
                end else begin
                    r_score <= r_score;
                end
            end else begin
                r_div   <= r_div + DIV_W'(1);
                r_score <= r_score;
            end
        end else begin
            r_grace <= r_grace;
            r_div   <= r_div;
            r_score <= r_score;
        end
    end

`ifdef HIGH_SCORE_EN
    // Best score since reset; r_score is already frozen on the OVER entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_score <= 14'd0;
        end else if (w_hit && (r_score > r_hi_score)) begin
            r_hi_score <= r_score;
        end else begin
            r_hi_score <= r_hi_score;
        end
    end

    assign bus.hi_score = r_hi_score;
`endif

    assign bus.game_state = r_state;
    assign bus.game_over  = r_game_over;
    assign bus.play_rst   = r_play_rst;
    assign bus.collision  = r_collision;
    assign bus.score      = r_score;

endmodule : game_ctrl_collision
